// File: rtl/fetch_module_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_module_pkg;

   // Byte distance between consecutive instruction words.
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // First fetch address after reset unless the instance overrides it.
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Default number of buffered fetch entries.
   localparam int unsigned FETCH_DEPTH_DEFAULT = 4;

   // Payload handed to decode: the address of the word and the word itself.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   // Instruction addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_module_fifo.sv
// Small synchronous FIFO holding fetched words until decode accepts them.
// The head entry is presented directly from storage; an empty FIFO never
// forwards the incoming push to its output in the same cycle.
module fetch_fifo
   import fetch_module_pkg::*;
#(
   parameter type T = fetch_t,
   parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output T                 head_data
);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is meaningless, so it is ignored rather than
   // letting the count underflow.
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push;

   // Pointers and occupancy; reset and flush both return to empty, and
   // pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (do_pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage is written only when a push really lands, so flushed
   // or reset cycles never leave stale words behind the tail.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && do_push) begin
         mem[tail_q] <= push_data;
      end
   end

   // Upstream credit accounting must never let a push arrive while full.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && do_push) begin
         assert (count_q < CNT_W'(DEPTH));
      end
   end

   assign count     = count_q;
   assign head_data = mem[head_q];

endmodule

// File: rtl/fetch_module.sv
// Instruction fetch front end: owns the PC, issues word reads to a
// one-cycle-latency instruction memory, and hands {pc, instr} pairs to
// decode through a small FIFO. Redirects flush everything and restart.
module fetch_module
   import fetch_module_pkg::*;
#(
   parameter type F = fetch_t,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_cons_o,
   input  logic        ready_cons_i,
   output F            data_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      pc_q;
   logic [31:0]      inflight_pc_q;
   logic             inflight_q;
   logic [CNT_W-1:0] queue_count;
   logic [CNT_W:0]   credit_used;
   logic             has_credit;
   logic             issue;
   logic             resp_push;
   logic             cons_pop;
   F                 resp_entry;

   // Credit counts both queued words and the word still coming back from
   // memory. It deliberately ignores this cycle's pop so that decode's
   // ready never reaches the memory request path combinationally.
   assign credit_used = {1'b0, queue_count} + {{CNT_W{1'b0}}, inflight_q};
   assign has_credit  = credit_used < (CNT_W + 1)'(DEPTH);

   assign issue       = reset_i && !redirect_valid_i && has_credit;
   assign imem_req_o  = issue;
   assign imem_addr_o = pc_q;

   // A returning word is dropped in a redirect cycle; the FIFO is being
   // flushed anyway and the word belongs to the abandoned path.
   assign resp_push  = inflight_q && !redirect_valid_i;
   assign resp_entry = F'({inflight_pc_q, imem_rdata_i});

   assign valid_cons_o = (queue_count != '0);
   assign cons_pop     = valid_cons_o && ready_cons_i;

   // PC, in-flight flag and the address of the outstanding read. Reset
   // beats redirect, and redirect beats normal issue.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         pc_q       <= word_align(RESET_PC);
         inflight_q <= 1'b0;
      end else if (redirect_valid_i) begin
         pc_q       <= word_align(redirect_pc_i);
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q          <= pc_q + INSTR_BYTES;
            inflight_pc_q <= pc_q;
         end
      end
   end

   fetch_fifo #(
      .T     (F),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (reset_i),
      .flush     (redirect_valid_i),
      .push      (resp_push),
      .push_data (resp_entry),
      .pop       (cons_pop),
      .count     (queue_count),
      .head_data (data_o)
   );

endmodule

// File: tb/tb_fetch_module.sv
// Self-checking bench for fetch_module: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference.
module tb_fetch_module;
   import fetch_module_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ready = 1'b0;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        valid_cons;
   fetch_t      data;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata = 32'hDEAD_BEEF;
   logic        w_valid;
   fetch_t      w_data;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: words queued for decode, the outstanding read, next PC.
   fetch_t      mq[$];
   int          m_infl = 0;
   logic [31:0] m_infl_pc = 32'h0;
   logic [31:0] m_pc = 32'h0;
   bit          model_live = 1'b0;

   logic        req_s = 1'b0;
   logic [31:0] addr_s = 32'h0;
   logic        w_req_s = 1'b0;
   logic [31:0] w_addr_s = 32'h0;

   // 10 time-unit clock period.
   always #5 clk = ~clk;

   fetch_module #(
      .F        (fetch_t),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .imem_req_o       (imem_req),
      .imem_addr_o      (imem_addr),
      .imem_rdata_i     (imem_rdata),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .valid_cons_o     (valid_cons),
      .ready_cons_i     (ready),
      .data_o           (data)
   );

   fetch_module #(
      .F        (fetch_t),
      .RESET_PC (WRAP_PC),
      .DEPTH    (DEPTH)
   ) dut_wrap (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .imem_req_o       (w_req),
      .imem_addr_o      (w_addr),
      .imem_rdata_i     (w_rdata),
      .redirect_valid_i (w_redirect),
      .redirect_pc_i    (w_redirect_pc),
      .valid_cons_o     (w_valid),
      .ready_cons_i     (ready),
      .data_o           (w_data)
   );

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ MEM_KEY;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic redir,
                                input logic [31:0] rpc, input logic rdy);
      reset_i        = rst;
      redirect_valid = redir;
      redirect_pc    = rpc;
      ready          = rdy;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic midCycle();
      @(negedge clk);
   endtask

   task automatic doReset(input logic rdy);
      applyStimulus(1'b0, 1'b0, 32'h0, rdy);
      nextCycle();
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, rdy);
   endtask

   // Memories capture the request mid-cycle and answer on the next edge.
   always @(negedge clk) begin
      req_s    = imem_req;
      addr_s   = imem_addr;
      w_req_s  = w_req;
      w_addr_s = w_addr;
   end

   // One-cycle-latency instruction memories returning addr ^ MEM_KEY.
   always @(posedge clk) begin
      imem_rdata <= req_s ? memWord(addr_s) : 32'hDEAD_BEEF;
      w_rdata    <= w_req_s ? memWord(w_addr_s) : 32'hDEAD_BEEF;
   end

   // Reference update at each edge from the inputs held during the cycle.
   always @(posedge clk) begin
      bit     u_req;
      bit     u_pop;
      fetch_t e;
      u_req = reset_i && !redirect_valid && ((mq.size() + m_infl) < int'(DEPTH));
      u_pop = (mq.size() != 0) && ready;
      if (!reset_i) begin
         mq.delete();
         m_infl     = 0;
         m_pc       = 32'h0;
         model_live = 1'b1;
      end else if (redirect_valid) begin
         mq.delete();
         m_infl = 0;
         m_pc   = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (u_pop) void'(mq.pop_front());
         if (m_infl != 0) begin
            e.pc    = m_infl_pc;
            e.instr = memWord(m_infl_pc);
            mq.push_back(e);
         end
         m_infl = u_req ? 1 : 0;
         if (u_req) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
   end

   // Every cycle, compare the main DUT's outputs with the reference.
   always @(negedge clk) begin
      bit c_req;
      if (model_live) begin
         c_req = reset_i && !redirect_valid && ((mq.size() + m_infl) < int'(DEPTH));
         checkOutput("cyc_req", 32'(imem_req), 32'(c_req));
         if (c_req) checkOutput("cyc_addr", imem_addr, m_pc);
         checkOutput("cyc_valid", 32'(valid_cons), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            checkOutput("cyc_pc", data.pc, mq[0].pc);
            checkOutput("cyc_instr", data.instr, mq[0].instr);
         end
      end
   end

   // Directed scenarios, then a randomized run, then the summary.
   initial begin
      logic        r_rst;
      logic        r_redir;
      logic [31:0] r_pc;
      logic        r_rdy;

      // Reset release with ready high: streaming from 0, and the wrap instance.
      doReset(1'b1);
      midCycle();
      checkOutput("t1_req0", 32'(imem_req), 32'd1);
      checkOutput("t1_addr0", imem_addr, 32'h0);
      checkOutput("t1_valid0", 32'(valid_cons), 32'd0);
      checkOutput("t5_addr0", w_addr, 32'hFFFF_FFF8);
      nextCycle();
      midCycle();
      checkOutput("t1_addr1", imem_addr, 32'h4);
      checkOutput("t1_valid1", 32'(valid_cons), 32'd0);
      checkOutput("t5_addr1", w_addr, 32'hFFFF_FFFC);
      nextCycle();
      midCycle();
      checkOutput("t1_addr2", imem_addr, 32'h8);
      checkOutput("t1_valid2", 32'(valid_cons), 32'd1);
      checkOutput("t1_pc2", data.pc, 32'h0);
      checkOutput("t1_instr2", data.instr, 32'hA5A5_0000);
      checkOutput("t5_addr2", w_addr, 32'h0);
      checkOutput("t5_pc2", w_data.pc, 32'hFFFF_FFF8);
      nextCycle();
      midCycle();
      checkOutput("t1_pc3", data.pc, 32'h4);
      checkOutput("t1_instr3", data.instr, 32'hA5A5_0004);
      checkOutput("t5_pc3", w_data.pc, 32'hFFFF_FFFC);
      nextCycle();
      midCycle();
      checkOutput("t1_pc4", data.pc, 32'h8);
      checkOutput("t5_valid4", 32'(w_valid), 32'd1);
      checkOutput("t5_pc4", w_data.pc, 32'h0);
      nextCycle();
      repeat (15) nextCycle();

      // Stalled consumer: queue fills to DEPTH, requests stop, then drains.
      doReset(1'b0);
      repeat (10) nextCycle();
      midCycle();
      checkOutput("t2_req", 32'(imem_req), 32'd0);
      checkOutput("t2_valid", 32'(valid_cons), 32'd1);
      checkOutput("t2_head", data.pc, 32'h0);
      checkOutput("t2_model_cnt", 32'(mq.size()), 32'd4);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         midCycle();
         checkOutput("t2_drain_valid", 32'(valid_cons), 32'd1);
         checkOutput("t2_drain_pc", data.pc, 32'(i * 4));
         nextCycle();
      end
      repeat (8) nextCycle();

      // Redirect with one word in flight and three queued.
      doReset(1'b0);
      repeat (4) nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
      midCycle();
      checkOutput("t3_req_redir", 32'(imem_req), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      midCycle();
      checkOutput("t3_valid_r1", 32'(valid_cons), 32'd0);
      checkOutput("t3_addr_r1", imem_addr, 32'h100);
      nextCycle();
      midCycle();
      checkOutput("t3_valid_r2", 32'(valid_cons), 32'd0);
      nextCycle();
      midCycle();
      checkOutput("t3_valid_r3", 32'(valid_cons), 32'd1);
      checkOutput("t3_pc_r3", data.pc, 32'h100);
      checkOutput("t3_instr_r3", data.instr, 32'hA5A5_0100);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (6) nextCycle();

      // Misaligned redirect target, then back-to-back redirects.
      applyStimulus(1'b1, 1'b1, 32'h203, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      midCycle();
      checkOutput("t4_addr_align", imem_addr, 32'h200);
      nextCycle();
      nextCycle();
      midCycle();
      checkOutput("t4_pc_align", data.pc, 32'h200);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h80, 1'b1);
      midCycle();
      checkOutput("t4_req_b2b", 32'(imem_req), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      midCycle();
      checkOutput("t4_addr_b2b", imem_addr, 32'h80);
      nextCycle();
      nextCycle();
      midCycle();
      checkOutput("t4_pc_b2b", data.pc, 32'h80);
      nextCycle();
      repeat (5) nextCycle();

      // Reset mid-stream with queued words and a read in flight.
      doReset(1'b0);
      repeat (4) nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      midCycle();
      checkOutput("t6_req_rst", 32'(imem_req), 32'd0);
      nextCycle();
      midCycle();
      checkOutput("t6_valid_after", 32'(valid_cons), 32'd0);
      checkOutput("t6_req_after", 32'(imem_req), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      midCycle();
      checkOutput("t6_addr_rel", imem_addr, 32'h0);
      checkOutput("t6_valid_rel", 32'(valid_cons), 32'd0);
      nextCycle();
      nextCycle();
      midCycle();
      checkOutput("t6_pc_first", data.pc, 32'h0);
      checkOutput("t6_instr_first", data.instr, 32'hA5A5_0000);
      nextCycle();

      // Randomized traffic: ready, redirects and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         r_rst   = ($urandom_range(0, 199) != 0);
         r_redir = ($urandom_range(0, 24) == 0);
         r_pc    = $urandom;
         r_rdy   = ($urandom_range(0, 3) != 0);
         applyStimulus(r_rst, r_redir, r_pc, r_rdy);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (10) nextCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
